// File: rtl/fifo_march_bist.sv
// fifo_march_bist: March C- self-test engine for the FIFO dual-port memory.
// Drives the memory strobes, addresses and data directly from registers.
// Checks each read word one cycle after its read strobe. Counts mismatches
// (saturating) and captures the address and element of the first one.
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | engine parked, waiting for BIST_EN && START
// S_M0    | up   : w0
// S_M1    | up   : r0, w1
// S_M2    | up   : r1, w0
// S_M3    | down : r0, w1
// S_M4    | down : r1, w0
// S_M5    | down : r0
// S_DRAIN | one cycle so the final M5 read data can be compared
// S_FIN   | result valid; DONE held until a new START or BIST_EN=0

module fifo_march_bist #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  WCLK,
    input  logic                  RST,
    input  logic                  BIST_EN,
    input  logic                  START,
    input  logic [1:0]            BG_SEL,
    output logic                  MEM_WINC,
    output logic [ADDR_WIDTH-1:0] MEM_WADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    output logic                  MEM_RINC,
    output logic [ADDR_WIDTH-1:0] MEM_RADDR,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  PASS,
    output logic [CNT_WIDTH-1:0]  FAIL_CNT,
    output logic [ADDR_WIDTH-1:0] FAIL_ADDR,
    output logic [2:0]            FAIL_ELEM
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_M0    = 4'd1,
        S_M1    = 4'd2,
        S_M2    = 4'd3,
        S_M3    = 4'd4,
        S_M4    = 4'd5,
        S_M5    = 4'd6,
        S_DRAIN = 4'd7,
        S_FIN   = 4'd8
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = '0;
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = '1;
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX    = '1;

    // Background word for an address; only the address parity matters.
    function automatic logic [DATA_WIDTH-1:0] bg_pattern(input logic [1:0] sel,
                                                         input logic odd);
        logic [DATA_WIDTH-1:0] p55;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            p55[i] = ((i % 2) == 0);
        end
        case (sel)
            2'b01:   return p55;
            2'b10:   return odd ? ~p55 : p55;
            default: return '0;
        endcase
    endfunction

    function automatic logic [2:0] elem_of(input state_t s);
        case (s)
            S_M1:    return 3'd1;
            S_M2:    return 3'd2;
            S_M3:    return 3'd3;
            S_M4:    return 3'd4;
            S_M5:    return 3'd5;
            default: return 3'd0;
        endcase
    endfunction

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    phase;     // M1-M4: 0 = read slot, 1 = write slot
    logic [1:0]              bg;

    state_t                  nxt_state;
    logic [ADDR_WIDTH-1:0]   nxt_addr;
    logic                    nxt_phase;
    logic                    start_run;
    logic                    nxt_rw_elem;
    logic                    nxt_write;
    logic                    nxt_read;
    logic                    nxt_wr_inv;
    logic                    nxt_rd_inv;
    logic [1:0]              bg_eff;
    logic [DATA_WIDTH-1:0]   nxt_pat;

    logic [DATA_WIDTH-1:0]   rd_exp;
    logic [2:0]              rd_elem;
    logic                    cmp_valid;
    logic [DATA_WIDTH-1:0]   cmp_exp;
    logic [ADDR_WIDTH-1:0]   cmp_addr;
    logic [2:0]              cmp_elem;
    logic                    mismatch;

    // Sequencing: pick the operation the memory sees in the following cycle.
    always_comb begin
        nxt_state = state;
        nxt_addr  = addr;
        nxt_phase = phase;
        start_run = 1'b0;
        case (state)
            S_IDLE, S_FIN: begin
                if (BIST_EN && START) begin
                    nxt_state = S_M0;
                    nxt_addr  = ADDR_FIRST;
                    nxt_phase = 1'b0;
                    start_run = 1'b1;
                end
            end
            S_M0: begin
                if (addr == ADDR_LAST) begin
                    nxt_state = S_M1;
                    nxt_addr  = ADDR_FIRST;
                    nxt_phase = 1'b0;
                end else begin
                    nxt_addr = addr + 1'b1;
                end
            end
            S_M1, S_M2: begin
                if (!phase) begin
                    nxt_phase = 1'b1;
                end else if (addr == ADDR_LAST) begin
                    nxt_state = (state == S_M1) ? S_M2 : S_M3;
                    nxt_addr  = (state == S_M1) ? ADDR_FIRST : ADDR_LAST;
                    nxt_phase = 1'b0;
                end else begin
                    nxt_addr  = addr + 1'b1;
                    nxt_phase = 1'b0;
                end
            end
            S_M3, S_M4: begin
                if (!phase) begin
                    nxt_phase = 1'b1;
                end else if (addr == ADDR_FIRST) begin
                    nxt_state = (state == S_M3) ? S_M4 : S_M5;
                    nxt_addr  = ADDR_LAST;
                    nxt_phase = 1'b0;
                end else begin
                    nxt_addr  = addr - 1'b1;
                    nxt_phase = 1'b0;
                end
            end
            S_M5: begin
                if (addr == ADDR_FIRST) begin
                    nxt_state = S_DRAIN;
                end else begin
                    nxt_addr = addr - 1'b1;
                end
            end
            S_DRAIN: nxt_state = S_FIN;
            default: nxt_state = S_IDLE;
        endcase

        // Dropping BIST_EN parks the engine from any state.
        if (!BIST_EN && state != S_IDLE) begin
            nxt_state = S_IDLE;
            nxt_phase = 1'b0;
            start_run = 1'b0;
        end

        nxt_rw_elem = (nxt_state == S_M1) || (nxt_state == S_M2) ||
                      (nxt_state == S_M3) || (nxt_state == S_M4);
        nxt_write   = (nxt_state == S_M0) || (nxt_rw_elem && nxt_phase);
        nxt_read    = (nxt_state == S_M5) || (nxt_rw_elem && !nxt_phase);
        nxt_wr_inv  = (nxt_state == S_M1) || (nxt_state == S_M3);
        nxt_rd_inv  = (nxt_state == S_M2) || (nxt_state == S_M4);
        // The first M0 write must already use the background being latched.
        bg_eff      = start_run ? BG_SEL : bg;
        nxt_pat     = bg_pattern(bg_eff, nxt_addr[0]);
    end

    // Mismatch on the word requested in the previous cycle.
    assign mismatch = cmp_valid && (MEM_RDATA != cmp_exp);

    // FSM state and registered memory-side / status outputs.
    always_ff @(posedge WCLK or negedge RST) begin
        if (!RST) begin
            state     <= S_IDLE;
            addr      <= '0;
            phase     <= 1'b0;
            bg        <= 2'b00;
            MEM_WINC  <= 1'b0;
            MEM_WADDR <= '0;
            MEM_WDATA <= '0;
            MEM_RINC  <= 1'b0;
            MEM_RADDR <= '0;
            rd_exp    <= '0;
            rd_elem   <= 3'd0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PASS      <= 1'b0;
        end else begin
            state <= nxt_state;
            addr  <= nxt_addr;
            phase <= nxt_phase;
            if (start_run) begin
                bg <= BG_SEL;
            end
            MEM_WINC <= nxt_write;
            if (nxt_write) begin
                MEM_WADDR <= nxt_addr;
                MEM_WDATA <= nxt_wr_inv ? ~nxt_pat : nxt_pat;
            end
            MEM_RINC <= nxt_read;
            if (nxt_read) begin
                MEM_RADDR <= nxt_addr;
                rd_exp    <= nxt_rd_inv ? ~nxt_pat : nxt_pat;
                rd_elem   <= elem_of(nxt_state);
            end
            BUSY <= (nxt_state != S_IDLE) && (nxt_state != S_FIN);
            DONE <= (nxt_state == S_FIN);
            // Includes the compare finishing in DRAIN; no compares run in FIN.
            PASS <= (nxt_state == S_FIN) && (FAIL_CNT == '0) && !mismatch;
        end
    end

    // Compare pipeline and first-failure capture.
    always_ff @(posedge WCLK or negedge RST) begin
        if (!RST) begin
            cmp_valid <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
            cmp_elem  <= 3'd0;
            FAIL_CNT  <= '0;
            FAIL_ADDR <= '0;
            FAIL_ELEM <= 3'd0;
        end else begin
            cmp_valid <= MEM_RINC && BIST_EN;
            cmp_exp   <= rd_exp;
            cmp_addr  <= MEM_RADDR;
            cmp_elem  <= rd_elem;
            if (start_run) begin
                FAIL_CNT  <= '0;
                FAIL_ADDR <= '0;
                FAIL_ELEM <= 3'd0;
            end else if (mismatch) begin
                if (FAIL_CNT == '0) begin
                    FAIL_ADDR <= cmp_addr;
                    FAIL_ELEM <= cmp_elem;
                end
                if (FAIL_CNT != CNT_MAX) begin
                    FAIL_CNT <= FAIL_CNT + 1'b1;
                end
            end
        end
    end

endmodule
